// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder backed by a single-port synchronous RAM with byte-lane writes and optional wait states.
// Optional error detection (ERR1/ERR2 response) is built only when AHB_SRAM_RESP_ERR_EN is defined.
module ahb_sram_responder #(
   parameter int unsigned  MEM_WORDS   = 4096,
   parameter logic [31:0]  BASE_ADDR   = 32'hF000_0000,
   parameter int           WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic [2:0]  o_state_dbg
);

   localparam int          AW      = $clog2(MEM_WORDS);
   localparam logic [2:0]  WS_LAST = 3'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_ACCESS = 3'd2,
      S_RDATA  = 3'd3,
      S_ERR1   = 3'd4,
      S_ERR2   = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_next;
   state_t          w_first;
   logic [2:0]      r_cnt;
   logic            r_write;
   logic [AW-1:0]   r_idx;
   logic [3:0]      r_be;
   logic [31:0]     r_rdata;
   logic [31:0]     r_mem [MEM_WORDS];

   logic [31:0]     w_off;
   logic [AW-1:0]   w_idx;
   logic [3:0]      w_be;
   logic            w_accept;
   logic            w_err;
   logic            w_ram_we;
   logic            w_ram_rd;
   logic            w_unused;

   assign w_off    = HADDR - BASE_ADDR;
   assign w_idx    = w_off[AW+1:2];
   assign w_accept = HREADY && HSEL && HTRANS[1];

   // Lane mask ignores the low address bits a misaligned access would use, so it aligns down.
   always_comb begin
      w_be = 4'b1111;
      case (HSIZE)
         3'b000:  w_be = 4'b0001 << HADDR[1:0];
         3'b001:  w_be = HADDR[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

`ifdef AHB_SRAM_RESP_ERR_EN
   localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;
   assign w_err = (HSIZE > 3'b010)
               || (HSIZE == 3'b001 && HADDR[0])
               || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
               || ({1'b0, w_off} >= LIMIT);
   assign w_unused = HTRANS[0];
`else
   assign w_err    = 1'b0;
   assign w_unused = ^{HTRANS[0], w_off};
`endif

   assign w_first = w_err ? S_ERR1 : ((WAIT_STATES != 0) ? S_WAIT : S_ACCESS);

   // A read holds HREADY low through its ACCESS cycle; the RAM output appears in RDATA.
   assign HREADY = !((r_state == S_WAIT) || (r_state == S_ERR1)
                  || (r_state == S_ACCESS && !r_write));
   assign w_ram_we    = (r_state == S_ACCESS) && r_write;
   assign w_ram_rd    = (r_state == S_ACCESS) && !r_write;
   assign HRDATA      = (r_state == S_RDATA) ? r_rdata : 32'd0;
   assign o_state_dbg = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_be    <= 4'b0000;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT && w_next == S_WAIT) ? r_cnt + 3'd1 : 3'd0;
         if (w_accept) begin
            r_write <= HWRITE;
            r_idx   <= w_idx;
            r_be    <= w_be;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      HRESP  = 1'b0;
      case (r_state)
         S_IDLE:   w_next = S_IDLE;
         S_WAIT:   if (r_cnt == WS_LAST) w_next = S_ACCESS;
         S_ACCESS: if (!r_write) w_next = S_RDATA;
         S_RDATA:  w_next = S_RDATA;
`ifdef AHB_SRAM_RESP_ERR_EN
         S_ERR1: begin
            HRESP  = 1'b1;
            w_next = S_ERR2;
         end
         S_ERR2:   HRESP = 1'b1;
`endif
         default:  w_next = S_IDLE;
      endcase
      // Any cycle with HREADY high ends the data phase and samples the next address phase.
      if (HREADY) w_next = w_accept ? w_first : S_IDLE;
   end

   // RAM is not reset; a write in its ACCESS cycle commits even if rst is asserted then.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (r_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
      if (w_ram_rd) r_rdata <= r_mem[r_idx];
   end

endmodule

// File: doc/ahb_sram_responder.md
# ahb_sram_responder

AHB-Lite responder (slave) backed by inferred single-port synchronous on-chip RAM, sitting on the response side of the SCR1 `imem_*`/`dmem_*` AHB master ports as a tightly-coupled memory alternative to the SDRAM path. It accepts pipelined address/data-phase transfers and applies HSIZE/HADDR byte-lane writes. It inserts a configurable number of wait states and returns OKAY or a two-cycle ERROR response.

## Interface
- `MEM_WORDS`, 4096: RAM depth in 32-bit words; power of two, ≥16.
- `BASE_ADDR`, 32'hF000_0000: byte address of word 0; aligned to `MEM_WORDS*4`.
- `WAIT_STATES`, 0: extra HREADY-low cycles per transfer, 0..7.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `HSEL` input 1: responder selected.
- `HADDR` input 32: byte address, address phase.
- `HTRANS` input 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HSIZE` input 3: 000 byte, 001 half, 010 word; others illegal.
- `HWRITE` input 1: 1 = write.
- `HWDATA` input 32: write data, data phase.
- `HREADY` output 1: transfer complete / bus ready.
- `HRESP` output 1: 0 OKAY, 1 ERROR.
- `HRDATA` output 32: read data.

## Operation
- An address phase is accepted on a rising edge where `HREADY`=1, `HSEL`=1 and `HTRANS[1]`=1. The block registers HADDR, HSIZE and HWRITE and enters the data phase. IDLE/BUSY transfers and HSEL=0 get a zero-wait OKAY with no RAM access.
- Word index = `(HADDR - BASE_ADDR) >> 2`, truncated to `log2(MEM_WORDS)` bits.
- Lanes are little-endian:
  - byte: lane `HADDR[1:0]`;
  - half: lanes {1,0} when `HADDR[1]`=0, lanes {3,2} when `HADDR[1]`=1;
  - word: all four lanes.
- Reads return the full 32-bit word. The master extracts the lanes.
- States:
  - IDLE: no data phase pending. HREADY=1.
  - WAIT: counts `WAIT_STATES` cycles, then enters ACCESS.
  - ACCESS, write: the byte-masked RAM write commits at the edge ending this cycle. HREADY=1.
  - ACCESS, read: issues the RAM read, then enters RDATA.
  - RDATA: drives HRDATA. HREADY=1.
  - ERR1: HRESP=1, HREADY=0.
  - ERR2: HRESP=1, HREADY=1.
- Transition on the cycle HREADY=1 ends a data phase: to WAIT/ACCESS/ERR1 if a new address phase is accepted on that same edge, else to IDLE.
- Error conditions; all drive ERR1 then ERR2, with no RAM write:
  - HSIZE > 010;
  - misaligned (half with `HADDR[0]`=1, word with `HADDR[1:0]`≠0);
  - address outside `[BASE_ADDR, BASE_ADDR+MEM_WORDS*4)`.
- During ERR2 the master may present IDLE or a new transfer. A new transfer is accepted normally.
- HRDATA = 0 except in RDATA.

## Timing
- Reset values: state IDLE, `HREADY`=1, `HRESP`=0, `HRDATA`=0, wait counter 0. RAM contents are not cleared.
- Write data phase = `1+WAIT_STATES` cycles. With `WAIT_STATES`=0 a write is zero-wait.
- Read data phase = `2+WAIT_STATES` cycles: HREADY low for `1+WAIT_STATES` cycles, then data together with HREADY=1.
- Back-to-back transfers are pipelined: the next address phase is accepted in the cycle the current data phase completes.
- Write then read of the same address back-to-back returns the new data. The write commits on the edge where the read address is accepted, and the RAM read issues at least one cycle later, so no bypass is needed.
- `HWDATA` is sampled only in the ACCESS cycle of a write.
- `rst` asserted mid-transfer: on the next edge the block returns to IDLE and the pending write is dropped (not committed unless it was in its ACCESS edge). Outputs take their reset values.
- HTRANS changes while HREADY=0 are ignored; the address phase is sampled only when HREADY=1.

## Configuration
- `AHB_SRAM_RESP_ERR_EN`: error detection.
  - Defined: ERR1/ERR2 behaviour as in Operation.
  - Undefined: the ERR states are not synthesised and HRESP is tied to 0.
    - Out-of-range addresses alias modulo `MEM_WORDS*4`.
    - Misaligned accesses align down to the HSIZE boundary.
    - HSIZE > 010 is treated as a word access.
    - All transfers complete OKAY.

## Test plan
- Reset, then idle: hold `rst`=1 for 2 cycles → HREADY=1, HRESP=0, HRDATA=0. HTRANS=IDLE → HREADY stays 1, no RAM write.
- Word write/read, `WAIT_STATES`=0: write 32'hDEADBEEF @BASE+0x10, then read @BASE+0x10 back-to-back → write completes with zero wait; read has HREADY low 1 cycle, then HRDATA=32'hDEADBEEF, HRESP=0.
- Byte lanes: write word 0 to BASE+0x20, then byte 8'hAA @+0x21 and half 16'h1234 @+0x22 → read of +0x20 returns 32'h1234AA00.
- Wait states, `WAIT_STATES`=3: read → HREADY low exactly 4 cycles; write → HREADY low exactly 3 cycles.
- Errors, macro defined: word read @BASE+0x02, and write @BASE+MEM_WORDS*4 → each gives ERR1 (HRESP=1, HREADY=0) then ERR2 (HRESP=1, HREADY=1). A subsequent read shows the memory is unchanged.
- Mid-transfer reset: start a read with `WAIT_STATES`=3, assert `rst` in the 2nd wait cycle → next cycle HREADY=1, HRESP=0, HRDATA=0. The next transfer completes normally.
